// File: rtl/conv_window_scheduler_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the convolution window scheduler.
package conv_window_scheduler_pkg;

    localparam int unsigned DefImgW  = 28;
    localparam int unsigned DefImgH  = 28;
    localparam int unsigned DefK     = 3;
    localparam int unsigned DefAddrW = 13;
    localparam int unsigned CoordW   = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Width of a kernel tap counter; never narrower than one bit.
    function automatic int unsigned kcnt_w(input int unsigned k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Combinational mapping of window/tap coordinates to image RAM and weight ROM addresses.
module conv_addr_gen
    import conv_window_scheduler_pkg::*;
#(
    parameter int unsigned IMG_W  = DefImgW,
    parameter int unsigned K      = DefK,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned KW     = kcnt_w(DefK)
) (
    input  logic [CoordW-1:0] row,
    input  logic [CoordW-1:0] col,
    input  logic [KW-1:0]     kr,
    input  logic [KW-1:0]     kc,
    output logic [ADDR_W-1:0] img_addr,
    output logic [3:0]        w_addr
);

    // Full 32-bit arithmetic, then truncate to the RAM address width.
    always_comb begin
        img_addr = ADDR_W'((32'(row) + 32'(kr)) * IMG_W + 32'(col) + 32'(kc));
        w_addr   = 4'(32'(kr) * K + 32'(kc));
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// Walks every valid KxK window in raster order, issuing RAM/ROM addresses and MAC strobes
// that line up with the one-cycle RAM read latency.
module conv_window_scheduler
    import conv_window_scheduler_pkg::*;
#(
    parameter int unsigned IMG_W  = DefImgW,
    parameter int unsigned IMG_H  = DefImgH,
    parameter int unsigned K      = DefK,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              enable,
    output logic [ADDR_W-1:0] img_addr,
    output logic [3:0]        w_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mac_last,
    output logic [CoordW-1:0] out_row,
    output logic [CoordW-1:0] out_col,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       KW     = kcnt_w(K);
    localparam logic [KW-1:0]     KMax   = KW'(K - 1);
    localparam logic [CoordW-1:0] ColMax = CoordW'(IMG_W - K);
    localparam logic [CoordW-1:0] RowMax = CoordW'(IMG_H - K);

    if (IMG_W * IMG_H > 2 ** ADDR_W) begin : g_addr_chk
        $error("conv_window_scheduler: image does not fit in ADDR_W address bits");
    end
    if (K > IMG_W || K > IMG_H || K * K > 16 ||
        IMG_W > 2 ** CoordW || IMG_H > 2 ** CoordW) begin : g_size_chk
        $error("conv_window_scheduler: unsupported kernel or image size");
    end

    state_e            state_q;
    logic [KW-1:0]     kc_q, kr_q, kc_d, kr_d;
    logic [CoordW-1:0] col_q, row_q, col_d, row_d;
    logic              issue, kc_wrap, kr_wrap, col_wrap, row_wrap, final_tap;
    logic [ADDR_W-1:0] img_addr_d;
    logic [3:0]        w_addr_d;

    assign issue     = (state_q == StRun) && enable;
    assign kc_wrap   = (kc_q == KMax);
    assign kr_wrap   = (kr_q == KMax);
    assign col_wrap  = (col_q == ColMax);
    assign row_wrap  = (row_q == RowMax);
    assign final_tap = kc_wrap && kr_wrap && col_wrap && row_wrap;

    // Nested counters, kc innermost; they wrap to zero after the final tap.
    always_comb begin
        kc_d  = kc_q;
        kr_d  = kr_q;
        col_d = col_q;
        row_d = row_q;
        if (state_q == StIdle) begin
            kc_d  = '0;
            kr_d  = '0;
            col_d = '0;
            row_d = '0;
        end else if (issue) begin
            kc_d = kc_wrap ? '0 : kc_q + KW'(1);
            if (kc_wrap) begin
                kr_d = kr_wrap ? '0 : kr_q + KW'(1);
                if (kr_wrap) begin
                    col_d = col_wrap ? '0 : col_q + CoordW'(1);
                    if (col_wrap) begin
                        row_d = row_wrap ? '0 : row_q + CoordW'(1);
                    end
                end
            end
        end
    end

    // Address is computed from the next counter values so the register presents the
    // address of the tap being issued in the current cycle.
    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .K      (K),
        .ADDR_W (ADDR_W),
        .KW     (KW)
    ) u_addr_gen (
        .row      (row_d),
        .col      (col_d),
        .kr       (kr_d),
        .kc       (kc_d),
        .img_addr (img_addr_d),
        .w_addr   (w_addr_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            kc_q     <= '0;
            kr_q     <= '0;
            col_q    <= '0;
            row_q    <= '0;
            img_addr <= '0;
            w_addr   <= '0;
            mac_clr  <= 1'b0;
            mac_en   <= 1'b0;
            mac_last <= 1'b0;
            out_row  <= '0;
            out_col  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            kc_q     <= kc_d;
            kr_q     <= kr_d;
            col_q    <= col_d;
            row_q    <= row_d;
            img_addr <= img_addr_d;
            w_addr   <= w_addr_d;
            mac_en   <= issue;
            mac_clr  <= issue && (kc_q == '0) && (kr_q == '0);
            mac_last <= issue && kc_wrap && kr_wrap;
            if (issue) begin
                out_row <= row_q;
                out_col <= col_q;
            end
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        busy    <= 1'b1;
                    end
                end
                StRun: begin
                    if (issue && final_tap) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
